alu_spi_responder: RTL
======================

ALU_SPI_RESPONDER -- requirements
Module: alu_spi_responder

Interface
REQ-001 Parameter REGISTER_SIZE, default Isa::REGISTER_SIZE, sets the operand and result width in bits.
REQ-002 Parameter OP_BITS, default $bits(Isa::AluOperation), sets the opcode field width.
REQ-003 i_clock  input  1  system clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 spi  Spi.SlaveSpi modport  interface  sclk (ignored), nss (active-low select), mosi (from master), miso (to master).
REQ-006 o_busy  output  1  high in every state except IDLE.

Function
REQ-007 The block SHALL implement states IDLE, RECEIVING, EXECUTE, RESPOND_START and RESPONDING, encoded one-hot.
REQ-008 Packet layout: PACKET_BITS = OP_BITS + 2*REGISTER_SIZE, ordered {B, A, op}, transmitted LSB first, so the opcode LSB arrives first.
REQ-009 IDLE: on an edge with nss=0 and mosi=1 (start marker), go to RECEIVING and clear the bit counter; otherwise stay; miso=0.
REQ-010 RECEIVING: sample mosi into packet[counter] on each edge; after PACKET_BITS samples, go to EXECUTE; miso=0.
REQ-011 EXECUTE: lasts one cycle; latch result = f(op, A, B) truncated to REGISTER_SIZE bits; go to RESPOND_START; miso=0.
REQ-012 RESPOND_START: drive miso=1 for exactly one cycle; go to RESPONDING and clear the counter.
REQ-013 RESPONDING: drive miso=result[counter], counter+1 per edge; after REGISTER_SIZE bits, go to IDLE with miso=0.
REQ-014 Timing: the first result bit is on miso exactly 3 cycles after the edge that samples the last operand bit.
REQ-015 Opcode map, using Isa encodings:
- ADD = A+B
- SUB = A-B, modulo 2^REGISTER_SIZE
- AND, OR, XOR: bitwise
- SLL = A << B[$clog2(REGISTER_SIZE)-1:0]
- SRL: logical right shift, same shift amount
- any undefined opcode returns 0
REQ-016 Abort: nss=1 on any edge in RECEIVING, EXECUTE, RESPOND_START or RESPONDING forces IDLE next cycle; miso=0; partial packet discarded.
REQ-017 mosi is ignored outside IDLE and RECEIVING; a start marker seen while busy SHALL NOT restart the transaction.
REQ-018 Counters SHALL saturate at their terminal count and never wrap within one transaction.

Reset
REQ-019 i_reset=1 on an edge forces IDLE, counters=0, packet=0, result=0, miso=0, o_busy=0, in any state including mid-transaction.
REQ-020 Reset takes priority over nss, mosi and every transition.

Configuration
REQ-021 With macro ALU_SPI_RESPONDER_MUL_EN defined, opcode MUL returns the low REGISTER_SIZE bits of A*B.
REQ-022 Without ALU_SPI_RESPONDER_MUL_EN, opcode MUL is treated as undefined (result 0) and no multiplier is synthesised.

Structure
REQ-023 Isa package holds REGISTER_SIZE, the AluOperation enum (including MUL), the AluPacket type and a new ALU_PACKET_BITS constant.
REQ-024 The state enum stays local to the module.
REQ-025 Opcode evaluation SHALL be a combinational sub-module alu_core (inputs op, A, B; output result), instantiated once.

Verification (REGISTER_SIZE=8)
REQ-026 Reset: hold i_reset=1 for 2 cycles mid-RECEIVING -> IDLE, miso=0, o_busy=0 next cycle.
REQ-027 ADD: start marker, then op=ADD, A=0x05, B=0x03 -> miso=1 for one cycle, then 0x08 LSB first (0,0,0,1,0,0,0,0), then miso=0.
REQ-028 SUB wrap: A=0x02, B=0x05 -> result 0xFD; SLL with A=0x81, B=0x09 (shift amount 1) -> result 0x02.
REQ-029 MUL: A=0x10, B=0x11 -> result 0x10 with the macro defined; 0x00 without it.
REQ-030 Abort: raise nss after 5 operand bits -> IDLE next cycle; a new full ADD transaction then completes correctly.
REQ-031 Back-to-back: two transactions with one idle cycle between them -> both results correct; first result bit appears 3 cycles after each last operand bit.

Source files
------------

// File: rtl/alu_spi_responder_pkg.sv
// Isa package: shared ALU instruction-set definitions for the SPI responder.
//   REGISTER_SIZE   - operand/result width in bits
//   AluOperation    - opcode encoding (MUL only honoured when the multiplier is built)
//   AluPacket       - serial packet layout {B, A, op}, op in the least significant bits
//   ALU_PACKET_BITS - total packet length in bits
package Isa;

    localparam int REGISTER_SIZE = 8;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SLL = 3'd5,
        SRL = 3'd6,
        MUL = 3'd7
    } AluOperation;

    typedef struct packed {
        logic [REGISTER_SIZE-1:0] b;
        logic [REGISTER_SIZE-1:0] a;
        AluOperation              op;
    } AluPacket;

    localparam int ALU_PACKET_BITS = $bits(AluPacket);

endpackage

// File: rtl/alu_spi_responder_spi.sv
// Spi interface: simple serial link between a master and the ALU responder.
//   sclk - serial clock (unused by the responder, which runs on the system clock)
//   nss  - active-low slave select
//   mosi - master-to-slave data
//   miso - slave-to-master data
interface Spi;
    logic sclk;
    logic nss;
    logic mosi;
    logic miso;

    modport SlaveSpi  (input sclk, input nss, input mosi, output miso);
    modport MasterSpi (output sclk, output nss, output mosi, input miso);
endinterface

// File: rtl/alu_spi_responder_alu_core.sv
// alu_core: purely combinational opcode evaluation for the SPI responder.
//   op     - opcode (Isa::AluOperation encoding)
//   a, b   - operands
//   result - f(op, a, b) truncated to REGISTER_SIZE bits; 0 for undefined opcodes
// Optional feature macro: ALU_SPI_RESPONDER_MUL_EN builds the MUL opcode;
// without it MUL is treated as undefined and no multiplier exists.
module alu_core
    import Isa::*;
#(
    parameter int REGISTER_SIZE = Isa::REGISTER_SIZE,
    parameter int OP_BITS       = $bits(Isa::AluOperation)
) (
    input  logic [OP_BITS-1:0]       op,
    input  logic [REGISTER_SIZE-1:0] a,
    input  logic [REGISTER_SIZE-1:0] b,
    output logic [REGISTER_SIZE-1:0] result
);

    localparam int SHAMT_W = $clog2(REGISTER_SIZE);

    // Shifts only use the low bits of B, so a shift never clears the whole word.
    logic [SHAMT_W-1:0] shamt_s;
    assign shamt_s = b[SHAMT_W-1:0];

    // Opcode decode; results are naturally modulo 2^REGISTER_SIZE by the result width.
    always_comb begin
        result = '0;
        case (op)
            OP_BITS'(ADD): result = a + b;
            OP_BITS'(SUB): result = a - b;
            OP_BITS'(AND): result = a & b;
            OP_BITS'(OR):  result = a | b;
            OP_BITS'(XOR): result = a ^ b;
            OP_BITS'(SLL): result = a << shamt_s;
            OP_BITS'(SRL): result = a >> shamt_s;
`ifdef ALU_SPI_RESPONDER_MUL_EN
            OP_BITS'(MUL): result = a * b;
`else
            OP_BITS'(MUL): result = '0;
`endif
            default:       result = '0;
        endcase
    end

endmodule

// File: rtl/alu_spi_responder.sv
// alu_spi_responder: receives an ALU packet serially over SPI (one bit per
// system clock), evaluates it, and serialises the result back on miso.
//   i_clock - system clock, rising edge
//   i_reset - synchronous active-high reset, highest priority
//   spi     - Spi.SlaveSpi: nss (active-low select), mosi in, miso out, sclk ignored
//   o_busy  - high whenever the responder is not IDLE
// Protocol: in IDLE a cycle with nss=0, mosi=1 is the start marker; the next
// PACKET_BITS cycles carry {B, A, op} LSB first. After one EXECUTE cycle,
// miso shows a single 1 (response start) followed by the result LSB first.
// miso is registered, so the first result bit appears three cycles after the
// edge that samples the last operand bit. nss=1 while busy aborts to IDLE.
// Optional feature macro: ALU_SPI_RESPONDER_MUL_EN (enables MUL in alu_core).
module alu_spi_responder
    import Isa::*;
#(
    parameter int REGISTER_SIZE = Isa::REGISTER_SIZE,
    parameter int OP_BITS       = $bits(Isa::AluOperation)
) (
    input  logic i_clock,
    input  logic i_reset,
    Spi.SlaveSpi spi,
    output logic o_busy
);

    localparam int PACKET_BITS = OP_BITS + 2 * REGISTER_SIZE;
    localparam int CNT_W       = $clog2(PACKET_BITS);
    localparam int RES_IDX_W   = $clog2(REGISTER_SIZE);

    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PACKET_BITS - 1);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(REGISTER_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [4:0] ST_IDLE          = 5'b00001;
    localparam logic [4:0] ST_RECEIVING     = 5'b00010;
    localparam logic [4:0] ST_EXECUTE       = 5'b00100;
    localparam logic [4:0] ST_RESPOND_START = 5'b01000;
    localparam logic [4:0] ST_RESPONDING    = 5'b10000;

    logic [4:0]               state_r,  state_s;
    logic [CNT_W-1:0]         cnt_r,    cnt_s;
    logic [PACKET_BITS-1:0]   packet_r, packet_s;
    logic [REGISTER_SIZE-1:0] result_r, result_s;
    logic                     miso_r,   miso_s;
    logic [REGISTER_SIZE-1:0] alu_result_s;

    alu_core #(
        .REGISTER_SIZE (REGISTER_SIZE),
        .OP_BITS       (OP_BITS)
    ) u_alu_core (
        .op     (packet_r[OP_BITS-1:0]),
        .a      (packet_r[OP_BITS +: REGISTER_SIZE]),
        .b      (packet_r[OP_BITS+REGISTER_SIZE +: REGISTER_SIZE]),
        .result (alu_result_s)
    );

    // Next-state and next-datapath logic; miso_s is the value shown during the next cycle.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        packet_s = packet_r;
        result_s = result_r;
        miso_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!spi.nss && spi.mosi) begin
                    state_s = ST_RECEIVING;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECEIVING: begin
                if (spi.nss) begin
                    // Abort: drop the partial packet so nothing stale survives.
                    state_s  = ST_IDLE;
                    cnt_s    = '0;
                    packet_s = '0;
                end else begin
                    packet_s[cnt_r] = spi.mosi;
                    // Counter holds at its terminal value instead of wrapping.
                    if (cnt_r == PKT_LAST) begin
                        state_s = ST_EXECUTE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
            end
            ST_EXECUTE: begin
                if (spi.nss) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    result_s = alu_result_s;
                    state_s  = ST_RESPOND_START;
                end
            end
            ST_RESPOND_START: begin
                if (spi.nss) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    miso_s  = 1'b1;
                    state_s = ST_RESPONDING;
                    cnt_s   = '0;
                end
            end
            ST_RESPONDING: begin
                if (spi.nss) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    miso_s = result_r[cnt_r[RES_IDX_W-1:0]];
                    if (cnt_r == RES_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
            end
            default: begin
                // Any non-one-hot value is treated as corruption and recovered to IDLE.
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State and datapath registers; reset overrides every transition.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            packet_r <= '0;
            result_r <= '0;
            miso_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            packet_r <= packet_s;
            result_r <= result_s;
            miso_r   <= miso_s;
        end
    end

    assign spi.miso = miso_r;
    assign o_busy   = (state_r != ST_IDLE);

endmodule
